// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets, FSM state encoding and ID constants for the
// platform interrupt controller.
package irq_ctrl_pkg;

  localparam logic [7:0] IRQ_ENABLE_REG   = 8'h00;
  localparam logic [7:0] IRQ_PENDING_REG  = 8'h04;
  localparam logic [7:0] IRQ_CLAIM_REG    = 8'h08;
  localparam logic [7:0] IRQ_COMPLETE_REG = 8'h0C;
  localparam logic [7:0] IRQ_TRIGGER_REG  = 8'h10;

  localparam logic [4:0] IRQ_NO_ID = 5'd0;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ASSERT  = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational priority encoder: reports the lowest set bit of req_i.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [4:0]         idx_o
);

  logic [NUM_SRC-1:0] shifted;

  // Scan from the top down so the lowest active index is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = IRQ_NO_ID;
    shifted = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      shifted = req_i >> (i - 1);
      if (shifted[0]) begin
        valid_o = 1'b1;
        idx_o   = 5'(i - 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Platform interrupt controller: pending/enable latching, lowest-index
// arbitration and claim/complete tracking. IRQ_CTRL_EDGE_EN adds edge triggers.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        data_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic               req_i,
  output logic [31:0]        data_o,
  output logic               ack_o,
  input  logic [NUM_SRC-1:0] int_src_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [4:0]         in_svc_q, in_svc_d;
  logic               irq_q, irq_d;
  logic               ack_q;

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] trigger_q, trigger_d;
  logic [NUM_SRC-1:0] prev_q;
`endif

  logic [7:0]         reg_sel;
  logic               wr_en, rd_en, claim_rd;
  logic [NUM_SRC-1:0] set_vec, w1c_vec, clr_vec, svc_mask, cand;
  logic               best_valid;
  logic [4:0]         best_idx;
  logic [4:0]         best_id;
  logic               unused_bits;

  assign unused_bits = ^{addr_i[31:8], data_i};

  always_comb begin
    svc_mask = '0;
    if (in_svc_q != IRQ_NO_ID) begin
      svc_mask[0] = 1'b1;
      svc_mask    = svc_mask << (in_svc_q - 5'd1);
    end
    cand = pending_q & enable_q & ~svc_mask;
  end

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC)
  ) u_prio_enc (
    .req_i  (cand),
    .valid_o(best_valid),
    .idx_o  (best_idx)
  );

  assign best_id = best_idx + 5'd1;

  always_comb begin
    reg_sel  = addr_i[7:0];
    wr_en    = req_i & we_i;
    rd_en    = req_i & ~we_i;
    claim_rd = rd_en && (reg_sel == IRQ_CLAIM_REG) && (state_q == IRQ_ASSERT) && best_valid;

    enable_d = enable_q;
    if (wr_en && reg_sel == IRQ_ENABLE_REG) enable_d = data_i[NUM_SRC-1:0];

    w1c_vec = '0;
    if (wr_en && reg_sel == IRQ_PENDING_REG) w1c_vec = data_i[NUM_SRC-1:0];

    clr_vec = '0;
    if (claim_rd) begin
      clr_vec[0] = 1'b1;
      clr_vec    = clr_vec << best_idx;
    end

`ifdef IRQ_CTRL_EDGE_EN
    trigger_d = trigger_q;
    if (wr_en && reg_sel == IRQ_TRIGGER_REG) trigger_d = data_i[NUM_SRC-1:0];
    set_vec = int_src_i & ~(trigger_q & prev_q);
`else
    set_vec = int_src_i;
`endif

    // New requests override both W1C and claim clears.
    pending_d = (pending_q & ~w1c_vec & ~clr_vec) | set_vec;

    state_d  = state_q;
    in_svc_d = in_svc_q;
    unique case (state_q)
      IRQ_IDLE:   if (best_valid) state_d = IRQ_ASSERT;
      IRQ_ASSERT: begin
        if (claim_rd) begin
          state_d  = IRQ_SERVICE;
          in_svc_d = best_id;
        end else if (!best_valid) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SERVICE: begin
        if (wr_en && reg_sel == IRQ_COMPLETE_REG && data_i[4:0] == in_svc_q) begin
          state_d  = IRQ_IDLE;
          in_svc_d = IRQ_NO_ID;
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_ASSERT);

    data_o = '0;
    if (!rst) begin
      unique case (reg_sel)
        IRQ_ENABLE_REG:   data_o[NUM_SRC-1:0] = enable_q;
        IRQ_PENDING_REG:  data_o[NUM_SRC-1:0] = pending_q;
        IRQ_CLAIM_REG:    if (claim_rd) data_o[4:0] = best_id;
        IRQ_COMPLETE_REG: data_o[4:0] = in_svc_q;
`ifdef IRQ_CTRL_EDGE_EN
        IRQ_TRIGGER_REG:  data_o[NUM_SRC-1:0] = trigger_q;
`endif
        default:          data_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      enable_q  <= '0;
      pending_q <= '0;
      in_svc_q  <= IRQ_NO_ID;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
      trigger_q <= '0;
      prev_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      in_svc_q  <= in_svc_d;
      irq_q     <= irq_d;
      ack_q     <= 1'b1;
`ifdef IRQ_CTRL_EDGE_EN
      trigger_q <= trigger_d;
      prev_q    <= int_src_i;
`endif
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = in_svc_q;
  assign ack_o    = ack_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Platform interrupt controller that sits directly downstream of the 32-bit timer and the other peripherals.
- Collects their interrupt lines (timer int_sig_o on source 0), latches them into pending bits and masks them with enables.
- Picks the lowest-index active source, drives one interrupt request to the core and tracks claim/complete handshakes through RIB-style register accesses.
- Sits on the same peripheral bus as the timer; the bus strips the base address.

Parameters:
- NUM_SRC, 8, number of interrupt sources; legal range 1..31; source i reports ID i+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- data_i  in  32  bus write data
- addr_i  in  32  bus address offset; only addr_i[7:0] decoded
- we_i  in  1  bus write enable
- req_i  in  1  bus request
- data_o  out  32  bus read data, combinational from addr_i
- ack_o  out  1  bus acknowledge
- int_src_i  in  NUM_SRC  peripheral interrupt lines, synchronous to clk, active-high
- irq_o  out  1  interrupt request to core
- irq_id_o  out  5  ID currently in service, 0 if none

Behaviour:
- Register map (offset, access):
  - 0x00 ENABLE, rw, bits [NUM_SRC-1:0].
  - 0x04 PENDING, read / write-1-to-clear.
  - 0x08 CLAIM, read with side effect.
  - 0x0C COMPLETE, write ID; read returns in-service ID.
  - Unmapped or unused bits read 0; writes to them are ignored.
- Reset: ENABLE, PENDING, in-service ID and state all 0; irq_o=0, irq_id_o=0, data_o=0, ack_o=0.
- ack_o: 0 during reset, 1 every cycle after (zero-wait-state).
- Pending, level mode: pending[i] is set at the clock edge when int_src_i[i]=1.
  - Set and W1C in the same cycle: set wins.
  - Claim clear and set in the same cycle: set wins.
- Selection: best = lowest i with pending[i] & enable[i], excluding the in-service source. A purely combinational priority encoder computes it.
- FSM states: IDLE, ASSERT, SERVICE.
  - IDLE -> ASSERT when any pending&enable bit is set.
  - ASSERT -> IDLE if the candidate vanishes (enable cleared, W1C) before a claim.
  - ASSERT -> SERVICE on a claim read (req_i=1, we_i=0, addr 0x08).
    - data_o = best+1 that cycle.
    - The in-service ID latches best+1.
    - pending[best] clears at the same edge.
  - SERVICE -> IDLE on a COMPLETE write whose data_i[4:0] equals the in-service ID; the in-service ID then clears.
  - A mismatched or zero COMPLETE is ignored.
- irq_o = (state==ASSERT), decoded from the registered state.
- Latency: source rises in cycle N -> pending in N+1 -> irq_o high in N+2.
- Claim read in IDLE or SERVICE returns 0 and has no side effect.
- A level source still high after complete re-pends and re-asserts; this is the required behaviour for the timer, which holds int_sig_o until software clears the timer pending bit.
- Only one interrupt is in service at a time; no nesting.
- Writes to ENABLE take effect at the next edge.
- A write to CLAIM is ignored.

Optional Feature:
- Macro: IRQ_CTRL_EDGE_EN.
- Defined:
  - Adds 0x10 TRIGGER rw register, bits [NUM_SRC-1:0], reset 0; a 1 selects rising-edge mode for that source.
  - A per-source previous-value register, reset 0, provides edge detection.
  - pending[i] is set only when int_src_i[i]=1 and the previous value was 0.
- Undefined: all sources are level mode; 0x10 reads 0 and writes are ignored; no edge registers exist.

Decomposition:
- Shared constants in defines.v:
  - Register offsets IRQ_ENABLE_REG, IRQ_PENDING_REG, IRQ_CLAIM_REG, IRQ_COMPLETE_REG, IRQ_TRIGGER_REG.
  - FSM encodings IRQ_IDLE, IRQ_ASSERT, IRQ_SERVICE (2 bits).
  - No-interrupt ID constant, 0.
- One sub-module, irq_prio_enc: input NUM_SRC-bit request vector; outputs valid and index.

Test Plan:
- Level timer interrupt: ENABLE=0x1, int_src_i[0]=1 at cycle 10 -> irq_o=1 in cycle 12. CLAIM read returns 1 -> irq_o=0, irq_id_o=1. COMPLETE write 1 with source still high -> irq_o=1 again 2 cycles later.
- Priority: ENABLE=0xFF, sources 3 and 5 high simultaneously -> first CLAIM returns 4. After COMPLETE 4 with source 3 dropped -> next CLAIM returns 6.
- Masking and W1C: source 2 high with ENABLE=0 -> PENDING reads 0x4, irq_o=0. Write PENDING=0x4 while source low -> reads 0. Set ENABLE=0x4 in ASSERT, then clear -> FSM returns to IDLE, irq_o=0.
- Mismatched complete: in SERVICE with ID 1, COMPLETE write 3 -> stays in SERVICE, irq_id_o=1. CLAIM read returns 0.
- Reset mid-service: rst=1 for one cycle in SERVICE -> all registers 0, irq_o=0, irq_id_o=0, ack_o=0 during reset, ack_o=1 after.
- Edge mode (IRQ_CTRL_EDGE_EN): TRIGGER=0x1, source 0 held high 20 cycles -> exactly one pend/claim. A second rising edge after complete -> irq_o asserts again.
